// File: rtl/tmc_pkg.sv
// Shared constants and state encoding for the TMC SPI master.
package tmc_pkg;

  localparam int unsigned TMC_FRAME_W  = 40;
  localparam int unsigned TMC_BITCNT_W = $clog2(TMC_FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } tmc_state_e;

endpackage

// File: rtl/tmc_sclk_gen.sv
// CLK_DIV half-period timer: a tick at the end of every CLK_DIV-cycle interval,
// split into SCLK rise/fall strobes while toggling is enabled.
module tmc_sclk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic toggle_en,
  input  logic sclk_lvl,
  output logic tick_c,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_c = en && (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d  = cnt_q + CNT_W'(1);
    if (!en || tick_c) begin
      cnt_d = '0;
    end
    rise_c = tick_c && toggle_en && !sclk_lvl;
    fall_c = tick_c && toggle_en && sclk_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tmc_spi_master.sv
// 40-bit SPI mode-3 master for TMC drivers. Define TMC_MISO_SYNC_EN to put
// spi_miso behind a 2-flop synchronizer with a matching 2-cycle sample delay.
module tmc_spi_master
  import tmc_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tmc_start,
  input  logic [TMC_FRAME_W-1:0] tmc_mosi_data,
  output logic [TMC_FRAME_W-1:0] tmc_miso_data,
  output logic                   tmc_busy,
  output logic                   tmc_done,
  output logic                   spi_csn,
  output logic                   spi_sclk,
  output logic                   spi_mosi,
  input  logic                   spi_miso
);

  tmc_state_e state_q, state_d;
  logic [TMC_FRAME_W-1:0]  tx_q, tx_d, rx_q, rx_d, miso_data_q, miso_data_d;
  logic [TMC_BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic busy_q, busy_d, done_q, done_d;
  logic tick_c, rise_c, fall_c, cap_c, cap_bit_c;

  tmc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != IDLE),
    .toggle_en(state_q == SETUP || state_q == SHIFT),
    .sclk_lvl (sclk_q),
    .tick_c   (tick_c),
    .rise_c   (rise_c),
    .fall_c   (fall_c)
  );

`ifdef TMC_MISO_SYNC_EN
  // The sample strobe trails each rise by the synchronizer depth, so it still
  // captures the bit that was on the pin at the rising edge.
  logic miso_s1_q, miso_s2_q, rise_d1_q, rise_d2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_s1_q <= 1'b0;
      miso_s2_q <= 1'b0;
      rise_d1_q <= 1'b0;
      rise_d2_q <= 1'b0;
    end else begin
      miso_s1_q <= spi_miso;
      miso_s2_q <= miso_s1_q;
      rise_d1_q <= rise_c;
      rise_d2_q <= rise_d1_q;
    end
  end

  assign cap_c     = rise_d2_q;
  assign cap_bit_c = miso_s2_q;
`else
  assign cap_c     = rise_c;
  assign cap_bit_c = spi_miso;
`endif

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    bitcnt_d    = bitcnt_q;
    csn_d       = csn_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (cap_c) begin
      rx_d = {rx_q[TMC_FRAME_W-2:0], cap_bit_c};
    end

    unique case (state_q)
      IDLE: begin
        if (tmc_start) begin
          tx_d     = tmc_mosi_data;
          mosi_d   = tmc_mosi_data[TMC_FRAME_W-1];
          csn_d    = 1'b0;
          busy_d   = 1'b1;
          bitcnt_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        if (fall_c) begin
          sclk_d  = 1'b0;
          mosi_d  = tx_q[TMC_FRAME_W-1];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // TX shifts on the rise so the next fall simply presents the new MSB.
        if (rise_c) begin
          sclk_d   = 1'b1;
          tx_d     = {tx_q[TMC_FRAME_W-2:0], 1'b0};
          bitcnt_d = bitcnt_q + TMC_BITCNT_W'(1);
        end else if (fall_c) begin
          if (bitcnt_q == TMC_BITCNT_W'(TMC_FRAME_W)) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b0;
            mosi_d = tx_q[TMC_FRAME_W-1];
          end
        end
      end
      HOLD: begin
        if (tick_c) begin
          csn_d   = 1'b1;
          mosi_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (tick_c) begin
          busy_d      = 1'b0;
          done_d      = 1'b1;
          miso_data_d = rx_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      bitcnt_q    <= '0;
      csn_q       <= 1'b1;
      sclk_q      <= 1'b1;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      bitcnt_q    <= bitcnt_d;
      csn_q       <= csn_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tmc_miso_data = miso_data_q;
  assign tmc_busy      = busy_q;
  assign tmc_done      = done_q;
  assign spi_csn       = csn_q;
  assign spi_sclk      = sclk_q;
  assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_tmc_spi_master.sv
// Bench for tmc_spi_master: time-indexed frame model checked every cycle, an
// SPI mode-3 observer/slave, and directed frames with literal expectations.
module tb_tmc_spi_master;

`ifdef TMC_MISO_SYNC_EN
  localparam int D           = 3;
  localparam bit LOOP        = 1'b1;
  localparam int EXP_LAT     = 250;
  localparam int EXP_CSN_LOW = 246;
  localparam int EXP_B2B     = 4;
`else
  localparam int D           = 4;
  localparam bit LOOP        = 1'b0;
  localparam int EXP_LAT     = 333;
  localparam int EXP_CSN_LOW = 328;
  localparam int EXP_B2B     = 5;
`endif

  logic        clk;
  logic        rst_n;
  logic        tmc_start;
  logic [39:0] tmc_mosi_data;
  logic [39:0] tmc_miso_data;
  logic        tmc_busy, tmc_done, spi_csn, spi_sclk, spi_mosi, spi_miso;

  tmc_spi_master #(.CLK_DIV(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tmc_start    (tmc_start),
    .tmc_mosi_data(tmc_mosi_data),
    .tmc_miso_data(tmc_miso_data),
    .tmc_busy     (tmc_busy),
    .tmc_done     (tmc_done),
    .spi_csn      (spi_csn),
    .spi_sclk     (spi_sclk),
    .spi_mosi     (spi_mosi),
    .spi_miso     (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks, failures;
  int done_total, rise_cnt, mosi_viol, csn_fall_cyc, last_csn_rise_cyc;
  logic [39:0] slave_frame, exp_tx, cap;
  logic prev_csn, prev_sclk, prev_mosi, prev_rst;

  // Model: a frame is m_k clk edges old; done comes at age 83*D.
  bit          m_active;
  int          m_k;
  logic [39:0] m_tx, m_rx_exp, m_miso_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active    <= 1'b0;
      m_k         <= 0;
      m_tx        <= '0;
      m_rx_exp    <= '0;
      m_miso_data <= '0;
    end else if (m_active && m_k < 83*D) begin
      m_k <= m_k + 1;
      if (m_k + 1 == 83*D) m_miso_data <= m_rx_exp;
    end else if (tmc_start) begin
      m_active <= 1'b1;
      m_k      <= 0;
      m_tx     <= tmc_mosi_data;
      m_rx_exp <= LOOP ? tmc_mosi_data : slave_frame;
    end else begin
      m_active <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    logic e_csn, e_sclk, e_mosi, e_busy, e_done;
    int bi;
    e_csn = 1'b1; e_sclk = 1'b1; e_mosi = 1'b0; e_busy = 1'b0; e_done = 1'b0;
    bi = 0;
    if (m_active && m_k == 83*D) begin
      e_done = 1'b1;
    end else if (m_active) begin
      e_busy = 1'b1;
      e_csn  = (m_k >= 82*D);
      if (m_k < D) bi = 39;
      else if (m_k < 81*D) begin
        bi     = 39 - (m_k - D) / (2*D);
        e_sclk = ((m_k - D) % (2*D)) >= D;
      end
      e_mosi = e_csn ? 1'b0 : m_tx[bi];
    end
    chk("csn",       64'(spi_csn),       64'(e_csn));
    chk("sclk",      64'(spi_sclk),      64'(e_sclk));
    chk("mosi",      64'(spi_mosi),      64'(e_mosi));
    chk("busy",      64'(tmc_busy),      64'(e_busy));
    chk("done",      64'(tmc_done),      64'(e_done));
    chk("miso_data", 64'(tmc_miso_data), 64'(m_miso_data));

    if (rst_n && prev_rst) begin
      if (prev_csn && !spi_csn) begin
        chk("sclk_at_csn_fall", 64'(spi_sclk), 64'(1));
        csn_fall_cyc = cyc; rise_cnt = 0; cap = '0; mosi_viol = 0;
      end else if (!prev_csn && !spi_csn) begin
        if (!prev_sclk && spi_sclk) begin
          rise_cnt++;
          cap = {cap[38:0], spi_mosi};
        end
        if (spi_mosi != prev_mosi && !(prev_sclk && !spi_sclk)) mosi_viol++;
      end else if (!prev_csn && spi_csn) begin
        chk("sclk_at_csn_rise", 64'(spi_sclk), 64'(1));
        chk("sclk_rises",       64'(rise_cnt), 64'(40));
        chk("mosi_off_fall",    64'(mosi_viol), 64'(0));
        chk("csn_low_len",      64'(cyc - csn_fall_cyc), 64'(EXP_CSN_LOW));
        chk("mosi_frame",       64'(cap), 64'(exp_tx));
        last_csn_rise_cyc = cyc;
      end
      if (tmc_done) done_total++;
    end

    if (LOOP) spi_miso = spi_mosi;
    else if (spi_csn) spi_miso = slave_frame[39];
    else if (prev_sclk && !spi_sclk && rise_cnt < 40) spi_miso = slave_frame[39 - rise_cnt];

    prev_csn = spi_csn; prev_sclk = spi_sclk; prev_mosi = spi_mosi; prev_rst = rst_n;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [39:0] tx, input logic [39:0] sf, output int sc);
    slave_frame   = sf;
    exp_tx        = tx;
    tmc_mosi_data = tx;
    tmc_start     = 1'b1;
    sc            = cyc;
    step();
    tmc_start     = 1'b0;
    tmc_mosi_data = ~tx;
  endtask

  task automatic wait_done(input string name, output int dc);
    dc = -1;
    for (int i = 0; i < EXP_LAT + 50; i++) begin
      step();
      if (tmc_done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) chk(name, 64'(0), 64'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_csn"},       64'(spi_csn),       64'(1));
    chk({tag, "_sclk"},      64'(spi_sclk),      64'(1));
    chk({tag, "_mosi"},      64'(spi_mosi),      64'(0));
    chk({tag, "_busy"},      64'(tmc_busy),      64'(0));
    chk({tag, "_done"},      64'(tmc_done),      64'(0));
    chk({tag, "_miso_data"}, 64'(tmc_miso_data), 64'(0));
  endtask

  initial begin
    int s0, s1, dc;
    logic [39:0] rx_a, rx_b, rx_c, rx_d;
    rst_n = 1'b0; tmc_start = 1'b0; tmc_mosi_data = '0; spi_miso = 1'b0;
    slave_frame = '0; exp_tx = '0; cap = '0;
    checks = 0; failures = 0; done_total = 0; rise_cnt = 0; mosi_viol = 0;
    csn_fall_cyc = 0; last_csn_rise_cyc = 0;
    prev_csn = 1'b1; prev_sclk = 1'b1; prev_mosi = 1'b0; prev_rst = 1'b0;
    rx_a = LOOP ? 40'hEC000100C3 : 40'h0F12345678;
    rx_b = LOOP ? 40'h6F00000000 : 40'h3C96A55AC3;
    rx_c = LOOP ? 40'hA5A5A5A5A5 : 40'h5A5A5A5A5A;
    rx_d = LOOP ? 40'h8000000001 : 40'h00FF00FF00;

    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none

    repeat (3) step();
    chk_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) step();

    // Reference frame with a stray start mid-transfer.
    start_frame(40'hEC000100C3, 40'h0F12345678, s0);
    while (cyc < s0 + 100) step();
    tmc_mosi_data = 40'hFFFFFFFFFF;
    tmc_start     = 1'b1;
    step();
    tmc_start     = 1'b0;
    wait_done("done_a_timeout", dc);
    chk("latency_a",    64'(dc - s0), 64'(EXP_LAT));
    chk("miso_data_a",  64'(tmc_miso_data), 64'(rx_a));
    chk("mosi_frame_a", 64'(cap), 64'(40'hEC000100C3));
    chk("done_count_a", 64'(done_total), 64'(1));
    chk("busy_in_done", 64'(tmc_busy), 64'(0));

    // Back-to-back start issued in the done cycle.
    start_frame(40'h6F00000000, 40'h3C96A55AC3, s1);
    chk("csn_high_b2b", 64'(csn_fall_cyc - last_csn_rise_cyc), 64'(EXP_B2B));
    wait_done("done_b_timeout", dc);
    chk("latency_b",    64'(dc - s1), 64'(EXP_LAT));
    chk("miso_data_b",  64'(tmc_miso_data), 64'(rx_b));
    chk("mosi_frame_b", 64'(cap), 64'(40'h6F00000000));

    // Reset after 20 SCLK rises aborts the frame silently.
    repeat (3) step();
    start_frame(40'h1234567890, 40'hFEDCBA9876, s0);
    for (int i = 0; i < 2*EXP_LAT && rise_cnt != 20; i++) step();
    chk("reached_20_rises", 64'(rise_cnt), 64'(20));
    rst_n = 1'b0;
    step();
    chk_reset_outputs("abort");
    repeat (2) step();
    rst_n = 1'b1;
    repeat (EXP_LAT + 20) step();
    chk("no_done_abort", 64'(done_total), 64'(2));
    start_frame(40'hA5A5A5A5A5, 40'h5A5A5A5A5A, s0);
    wait_done("done_c_timeout", dc);
    chk("latency_c",    64'(dc - s0), 64'(EXP_LAT));
    chk("miso_data_c",  64'(tmc_miso_data), 64'(rx_c));
    chk("mosi_frame_c", 64'(cap), 64'(40'hA5A5A5A5A5));

    // Edge bits only.
    start_frame(40'h8000000001, 40'h00FF00FF00, s0);
    wait_done("done_d_timeout", dc);
    chk("latency_d",    64'(dc - s0), 64'(EXP_LAT));
    chk("miso_data_d",  64'(tmc_miso_data), 64'(rx_d));
    chk("done_total",   64'(done_total), 64'(4));
    repeat (3*D) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
